// File: rtl/cpu_core.sv
// Single-cycle 32-bit MIPS-I core with instruction memory, data memory and register file.
// Optional mul/div support is enabled by defining MULDIV_EN.

module cpu_inst_mem #(
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic [29:0] addr,
  output logic [31:0] rdata
);
  localparam int unsigned AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  logic [31:0] inst [0:IMEM_WORDS-1];
  logic [29:0] word;

  always_comb begin
    word  = addr % 30'(IMEM_WORDS);
    rdata = inst[AW'(word)];
  end
endmodule

module cpu_data_mem #(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        we,
  input  logic [29:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int unsigned AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  logic [31:0] data [0:DMEM_WORDS-1];
  logic [29:0] word;

  always_comb begin
    word  = addr % 30'(DMEM_WORDS);
    rdata = data[AW'(word)];
  end

  // Not reset, so preloaded contents survive reset.
  always_ff @(posedge clk) begin
    if (we) data[AW'(word)] <= wdata;
  end
endmodule

module cpu_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [0:31];

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

  // r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end
endmodule

module cpu_core #(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input logic clk,
  input logic rst
);
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic [31:0] instr;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] ea;
  logic [31:0] dm_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dm_we;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] imm26;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm16 = instr[15:0];
  assign imm26 = instr[25:0];

  assign pc4  = pc + 32'd4;
  assign sext = {{16{imm16[15]}}, imm16};
  assign zext = {16'd0, imm16};
  assign ea   = a + sext;

  cpu_inst_mem #(.IMEM_WORDS(IMEM_WORDS)) inst_mem (
    .addr  (pc[31:2]),
    .rdata (instr)
  );

  cpu_data_mem #(.DMEM_WORDS(DMEM_WORDS)) data_mem (
    .clk   (clk),
    .we    (dm_we & rst),
    .addr  (ea[31:2]),
    .wdata (b),
    .rdata (dm_rdata)
  );

  cpu_reg_file reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (a),
    .rd2 (b),
    .we  (rf_we),
    .wa  (rf_waddr),
    .wd  (rf_wdata)
  );

  // Decode/execute: unsupported encodings fall through to a NOP with PC+4.
  always_comb begin
    next_pc  = pc4;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = 32'd0;
    dm_we    = 1'b0;
    case (op)
      6'h00: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        case (funct)
          6'h20, 6'h21: rf_wdata = a + b;
          6'h22, 6'h23: rf_wdata = a - b;
          6'h24:        rf_wdata = a & b;
          6'h25:        rf_wdata = a | b;
          6'h26:        rf_wdata = a ^ b;
          6'h27:        rf_wdata = ~(a | b);
          6'h2A:        rf_wdata = {31'd0, $signed(a) < $signed(b)};
          6'h2B:        rf_wdata = {31'd0, a < b};
          6'h00:        rf_wdata = b << shamt;
          6'h02:        rf_wdata = b >> shamt;
          6'h03:        rf_wdata = 32'($signed(b) >>> shamt);
          6'h08: begin
            rf_we   = 1'b0;
            next_pc = a;
          end
`ifdef MULDIV_EN
          6'h18:        rf_wdata = 32'($signed(a) * $signed(b));
          6'h1A:        rf_wdata = (b == 32'd0) ? 32'd0 : 32'($signed(a) / $signed(b));
`endif
          default:      rf_we = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin rf_we = 1'b1; rf_wdata = a + sext; end
      6'h0A: begin rf_we = 1'b1; rf_wdata = {31'd0, $signed(a) < $signed(sext)}; end
      6'h0B: begin rf_we = 1'b1; rf_wdata = {31'd0, a < sext}; end
      6'h0C: begin rf_we = 1'b1; rf_wdata = a & zext; end
      6'h0D: begin rf_we = 1'b1; rf_wdata = a | zext; end
      6'h0E: begin rf_we = 1'b1; rf_wdata = a ^ zext; end
      6'h0F: begin rf_we = 1'b1; rf_wdata = {imm16, 16'h0000}; end
      6'h23: begin rf_we = 1'b1; rf_wdata = dm_rdata; end
      6'h2B: dm_we = 1'b1;
      6'h04: if (a == b) next_pc = pc4 + {sext[29:0], 2'b00};
      6'h05: if (a != b) next_pc = pc4 + {sext[29:0], 2'b00};
      6'h02: next_pc = {pc4[31:28], imm26, 2'b00};
      6'h03: begin
        next_pc  = {pc4[31:28], imm26, 2'b00};
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        rf_wdata = pc4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'd0;
    else      pc <= next_pc;
  end
endmodule

// File: tb/tb_cpu_core.sv
// Directed self-checking bench for cpu_core; expectations follow MULDIV_EN when defined.

module tb_cpu_core;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cpu_core dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold reset and fill instruction memory with sll r0,r0,0 (a harmless NOP).
  task automatic start_prog();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) dut.inst_mem.inst[i] = 32'd0;
  endtask

  task automatic run(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;

    // Reset state
    #12;
    check("reset_pc", dut.pc, 32'd0);
    check("reset_r1", dut.reg_file.regs[1], 32'd0);

    // addi/addi/add
    start_prog();
    dut.inst_mem.inst[0] = itype(6'h08, 5'd0, 5'd1, 16'd5);
    dut.inst_mem.inst[1] = itype(6'h08, 5'd0, 5'd2, 16'hFFFD);
    dut.inst_mem.inst[2] = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    run(3);
    check("add_r1", dut.reg_file.regs[1], 32'd5);
    check("add_r2", dut.reg_file.regs[2], 32'hFFFF_FFFD);
    check("add_r3", dut.reg_file.regs[3], 32'd2);
    check("add_pc", dut.pc, 32'd12);

    // lui/ori/sw/lw
    start_prog();
    dut.inst_mem.inst[0] = itype(6'h0F, 5'd0, 5'd1, 16'h1234);
    dut.inst_mem.inst[1] = itype(6'h0D, 5'd1, 5'd1, 16'h5678);
    dut.inst_mem.inst[2] = itype(6'h2B, 5'd0, 5'd1, 16'd8);
    dut.inst_mem.inst[3] = itype(6'h23, 5'd0, 5'd4, 16'd8);
    run(4);
    check("sw_data2", dut.data_mem.data[2], 32'h1234_5678);
    check("lw_r4", dut.reg_file.regs[4], 32'h1234_5678);
    check("lw_pc", dut.pc, 32'd16);

    // Asynchronous reset mid-instruction keeps data memory
    #2;
    rst = 1'b0;
    #1;
    check("arst_pc", dut.pc, 32'd0);
    check("arst_r4", dut.reg_file.regs[4], 32'd0);
    check("arst_r1", dut.reg_file.regs[1], 32'd0);
    check("arst_data2", dut.data_mem.data[2], 32'h1234_5678);

    // beq taken
    start_prog();
    dut.inst_mem.inst[0] = itype(6'h04, 5'd0, 5'd0, 16'd2);
    run(1);
    check("beq_pc", dut.pc, 32'd12);

    // bne not taken
    start_prog();
    dut.inst_mem.inst[0] = itype(6'h05, 5'd0, 5'd0, 16'd2);
    run(1);
    check("bne_pc", dut.pc, 32'd4);

    // jal
    start_prog();
    dut.inst_mem.inst[0] = {6'h03, 26'h10};
    run(1);
    check("jal_pc", dut.pc, 32'h40);
    check("jal_r31", dut.reg_file.regs[31], 32'd4);

    // r0 write discarded, undefined opcode is a NOP
    start_prog();
    dut.inst_mem.inst[0] = itype(6'h08, 5'd0, 5'd5, 16'd9);
    dut.inst_mem.inst[1] = itype(6'h2B, 5'd0, 5'd5, 16'd20);
    dut.inst_mem.inst[2] = itype(6'h08, 5'd0, 5'd0, 16'd7);
    dut.inst_mem.inst[3] = itype(6'h3F, 5'd0, 5'd5, 16'd20);
    run(4);
    check("r0_zero", dut.reg_file.regs[0], 32'd0);
    check("undef_r5", dut.reg_file.regs[5], 32'd9);
    check("undef_data5", dut.data_mem.data[5], 32'd9);
    check("undef_pc", dut.pc, 32'd16);

    // ALU mix, immediates and jr
    start_prog();
    dut.inst_mem.inst[0]  = itype(6'h08, 5'd0, 5'd1, 16'hFFFA);
    dut.inst_mem.inst[1]  = itype(6'h08, 5'd0, 5'd2, 16'd4);
    dut.inst_mem.inst[2]  = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A);
    dut.inst_mem.inst[3]  = rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h2B);
    dut.inst_mem.inst[4]  = rtype(5'd0, 5'd1, 5'd5, 5'd1, 6'h03);
    dut.inst_mem.inst[5]  = rtype(5'd0, 5'd1, 5'd6, 5'd28, 6'h02);
    dut.inst_mem.inst[6]  = rtype(5'd0, 5'd2, 5'd7, 5'd4, 6'h00);
    dut.inst_mem.inst[7]  = rtype(5'd0, 5'd0, 5'd8, 5'd0, 6'h27);
    dut.inst_mem.inst[8]  = rtype(5'd2, 5'd1, 5'd9, 5'd0, 6'h22);
    dut.inst_mem.inst[9]  = itype(6'h0E, 5'd1, 5'd10, 16'hFFFF);
    dut.inst_mem.inst[10] = itype(6'h0B, 5'd2, 5'd11, 16'hFFFF);
    dut.inst_mem.inst[11] = itype(6'h0C, 5'd1, 5'd12, 16'h8000);
    dut.inst_mem.inst[12] = itype(6'h08, 5'd0, 5'd13, 16'h0040);
    dut.inst_mem.inst[13] = rtype(5'd13, 5'd0, 5'd0, 5'd0, 6'h08);
    run(14);
    check("slt_r3", dut.reg_file.regs[3], 32'd1);
    check("sltu_r4", dut.reg_file.regs[4], 32'd0);
    check("sra_r5", dut.reg_file.regs[5], 32'hFFFF_FFFD);
    check("srl_r6", dut.reg_file.regs[6], 32'h0000_000F);
    check("sll_r7", dut.reg_file.regs[7], 32'h0000_0040);
    check("nor_r8", dut.reg_file.regs[8], 32'hFFFF_FFFF);
    check("sub_r9", dut.reg_file.regs[9], 32'd10);
    check("xori_r10", dut.reg_file.regs[10], 32'hFFFF_0005);
    check("sltiu_r11", dut.reg_file.regs[11], 32'd1);
    check("andi_r12", dut.reg_file.regs[12], 32'h0000_8000);
    check("jr_pc", dut.pc, 32'h40);

    // mul/div (or NOPs when the option is absent)
    start_prog();
    dut.inst_mem.inst[0] = itype(6'h08, 5'd0, 5'd1, 16'hFFFA);
    dut.inst_mem.inst[1] = itype(6'h08, 5'd0, 5'd2, 16'd4);
    dut.inst_mem.inst[2] = itype(6'h08, 5'd0, 5'd3, 16'd7);
    dut.inst_mem.inst[3] = itype(6'h08, 5'd0, 5'd4, 16'd8);
    dut.inst_mem.inst[4] = itype(6'h08, 5'd0, 5'd5, 16'd9);
    dut.inst_mem.inst[5] = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h18);
    dut.inst_mem.inst[6] = rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h1A);
    dut.inst_mem.inst[7] = rtype(5'd1, 5'd0, 5'd5, 5'd0, 6'h1A);
    run(8);
`ifdef MULDIV_EN
    check("mul_r3", dut.reg_file.regs[3], 32'hFFFF_FFE8);
    check("div_r4", dut.reg_file.regs[4], 32'hFFFF_FFFF);
    check("div0_r5", dut.reg_file.regs[5], 32'd0);
`else
    check("mul_r3", dut.reg_file.regs[3], 32'd7);
    check("div_r4", dut.reg_file.regs[4], 32'd8);
    check("div0_r5", dut.reg_file.regs[5], 32'd9);
`endif
    check("muldiv_pc", dut.pc, 32'd32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter IMEM_WORDS, default 1024, instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 1024, data memory depth in 32-bit words.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have no other ports; all observation is through hierarchical names.
REQ-006 Hierarchy SHALL be: inst_mem.inst[0:IMEM_WORDS-1] (32b), data_mem.data[0:DMEM_WORDS-1] (32b), reg_file.regs[0:31] (32b).
REQ-007 inst_mem.inst and data_mem.data SHALL be plain reg arrays, so a bench can preload them with $readmemb or $readmemh.

Function
REQ-008 Core SHALL be single-cycle, 32-bit, MIPS-I encoding: one instruction retired per rising clk edge.
REQ-009 PC is a byte address; fetch inst_mem.inst[PC[..:2] mod IMEM_WORDS], combinational.
REQ-010 Default next PC SHALL be PC+4, wrapping modulo 2^32.
REQ-011 R-type (op 0) SHALL support funct add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B, sll 0x00, srl 0x02, sra 0x03, jr 0x08; results go to rd.
REQ-012 I-type SHALL support addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B, andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05; results go to rt.
REQ-013 J-type SHALL support j 0x02 and jal 0x03 (r31 <= PC+4); target = {PC+4[31:28], imm26, 2'b00}.
REQ-014 Immediates SHALL be sign-extended, except andi/ori/xori, which zero-extend; lui writes {imm16,16'h0}.
REQ-015 Branch taken target SHALL be PC+4+(sext(imm16)<<2); there is no delay slot.
REQ-016 Arithmetic SHALL wrap modulo 2^32; overflow SHALL NOT trap.
REQ-017 slt/slti compare signed; sltu/sltiu compare unsigned; result is 1 or 0.
REQ-018 lw/sw effective address is rs+sext(imm16); word index = addr[..:2] mod DMEM_WORDS; addr[1:0] SHALL be ignored.
REQ-019 lw data SHALL be read combinationally; sw SHALL write data_mem.data at the rising edge.
REQ-020 Register file SHALL have two combinational read ports and one write port written at the rising edge.
REQ-021 Writes to r0 SHALL be discarded; r0 always reads 0.
REQ-022 Unsupported opcode/funct SHALL execute as NOP: no register or memory write, PC+4.
REQ-023 Same-cycle read and write of the same register: the read SHALL return the old value.

Reset
REQ-024 While rst=0, PC SHALL be 0 and regs[1..31] SHALL be 0, and no memory write SHALL occur.
REQ-025 Asserting reset mid-instruction SHALL abort the instruction immediately, without waiting for a clock edge.
REQ-026 inst_mem and data_mem SHALL NOT be cleared by reset, so preloaded contents survive.
REQ-027 First fetch after rst rises SHALL be address 0; the first instruction retires at the first rising edge after release.

Configuration
REQ-028 Macro MULDIV_EN defined: R-type funct 0x18 (mul) SHALL write the low 32 bits of rs*rt (signed) to rd, and funct 0x1A (div) SHALL write rs/rt (signed, truncated) to rd.
REQ-029 div by zero SHALL write 0.
REQ-030 Macro MULDIV_EN undefined: funct 0x18 and 0x1A SHALL be NOPs per REQ-022, and no multiplier/divider SHALL be synthesized.

Verification
REQ-031 Preload addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; release reset -> after 3 edges r3=2, PC=12.
REQ-032 lui r1,0x1234; ori r1,r1,0x5678; sw r1,8(r0); lw r4,8(r0) -> data[2]=0x12345678, r4=0x12345678.
REQ-033 beq r0,r0,+2 at PC 0 -> next PC 12; bne r0,r0,+2 -> next PC 4; jal 0x10 -> PC 0x40, r31=4.
REQ-034 addi r0,r0,7 -> r0 remains 0; undefined opcode 0x3F -> no register or memory change, PC advances 4.
REQ-035 Pull rst low mid-program -> PC=0 and regs cleared immediately, data_mem contents retained.
REQ-036 With MULDIV_EN: r1=-6, r2=4, mul r3 -> -24, div r4 -> -1; div by r0 -> 0. Without MULDIV_EN: r3 and r4 unchanged.
